// File: rtl/jpeg_dqt_loader.sv
// JPEG DQT segment sequencer: parses length + [Pq|Tq] tables and feeds the dequantiser config port.
// Optional 16-bit (Pq=1) table support is built when JPEG_DQT_16BIT_EN is defined.
module jpeg_dqt_loader (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       img_start_i,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  output logic       inport_accept_o,
  output logic       cfg_valid_o,
  output logic [7:0] cfg_data_o,
  output logic       cfg_last_o,
  input  logic       cfg_accept_i,
  output logic [3:0] tables_loaded_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_TQ,
    S_DATA,
    S_DRAIN,
    S_PAD
`ifdef JPEG_DQT_16BIT_EN
    , S_DATA_HI
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] rem_q, rem_d;
  logic [5:0]  entry_q, entry_d;
  logic [1:0]  tq_q, tq_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [3:0]  loaded_q, loaded_d;
  logic        error_q, error_d;
  logic        done_q, done_d;
`ifdef JPEG_DQT_16BIT_EN
  logic        pq_q, pq_d;
  logic [7:0]  msb_q, msb_d;
`endif

  logic        can_load;
  logic        emit;
  logic [7:0]  emit_data;
  logic        emit_last;
  logic        set_err;
  logic [3:0]  set_loaded;
  logic [15:0] rem_dec;
  logic [15:0] seg_len;
  logic        hdr_bad;

  assign can_load = !out_valid_q || cfg_accept_i;
  assign rem_dec  = rem_q - 16'd1;
  assign seg_len  = {len_hi_q, inport_data_i};

`ifdef JPEG_DQT_16BIT_EN
  assign hdr_bad = (inport_data_i[3:0] > 4'd3) || (inport_data_i[7:4] > 4'd1);
`else
  assign hdr_bad = (inport_data_i[3:0] > 4'd3) || (inport_data_i[7:4] != 4'd0);
`endif

  always_comb begin
    state_d         = state_q;
    len_hi_d        = len_hi_q;
    rem_d           = rem_q;
    entry_d         = entry_q;
    tq_d            = tq_q;
    done_d          = 1'b0;
    inport_accept_o = 1'b0;
    emit            = 1'b0;
    emit_data       = '0;
    emit_last       = 1'b0;
    set_err         = 1'b0;
    set_loaded      = '0;
`ifdef JPEG_DQT_16BIT_EN
    pq_d            = pq_q;
    msb_d           = msb_q;
`endif

    case (state_q)
      S_IDLE: begin
        inport_accept_o = 1'b1;
        if (inport_valid_i) begin
          len_hi_d = inport_data_i;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        inport_accept_o = 1'b1;
        if (inport_valid_i) begin
          if (seg_len < 16'd2) begin
            set_err = 1'b1;
            rem_d   = '0;
            state_d = S_DRAIN;
          end else if (seg_len == 16'd2) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d   = seg_len - 16'd2;
            state_d = S_TQ;
          end
        end
      end
      S_TQ: begin
        inport_accept_o = can_load;
        if (inport_valid_i && can_load) begin
          rem_d   = rem_dec;
          tq_d    = inport_data_i[1:0];
          entry_d = '0;
          if (hdr_bad) begin
            set_err = 1'b1;
            state_d = S_DRAIN;
          end else begin
            emit      = 1'b1;
            emit_data = {6'b0, inport_data_i[1:0]};
`ifdef JPEG_DQT_16BIT_EN
            pq_d = inport_data_i[4];
`endif
            if (rem_dec == 16'd0) begin
              set_err = 1'b1;
              state_d = S_PAD;
`ifdef JPEG_DQT_16BIT_EN
            end else if (inport_data_i[4]) begin
              state_d = S_DATA_HI;
`endif
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
`ifdef JPEG_DQT_16BIT_EN
      S_DATA_HI: begin
        inport_accept_o = can_load;
        if (inport_valid_i && can_load) begin
          msb_d = inport_data_i;
          rem_d = rem_dec;
          if (rem_dec == 16'd0) begin
            set_err = 1'b1;
            state_d = S_PAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
`endif
      S_DATA: begin
        inport_accept_o = can_load;
        if (inport_valid_i && can_load) begin
          rem_d     = rem_dec;
          emit      = 1'b1;
          emit_last = (entry_q == 6'd63);
`ifdef JPEG_DQT_16BIT_EN
          emit_data = (pq_q && (msb_q != 8'd0)) ? 8'hFF : inport_data_i;
`else
          emit_data = inport_data_i;
`endif
          if (entry_q == 6'd63) begin
            if (rem_dec == 16'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_TQ;
            end
          end else begin
            entry_d = entry_q + 6'd1;
            if (rem_dec == 16'd0) begin
              set_err = 1'b1;
              state_d = S_PAD;
`ifdef JPEG_DQT_16BIT_EN
            end else if (pq_q) begin
              state_d = S_DATA_HI;
`endif
            end
          end
        end
      end
      S_DRAIN: begin
        // Stop accepting once the count is spent so the next segment's first byte is not swallowed.
        if (rem_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          inport_accept_o = 1'b1;
          if (inport_valid_i) rem_d = rem_dec;
        end
      end
      S_PAD: begin
        if (can_load) begin
          emit      = 1'b1;
          emit_data = 8'h01;
          emit_last = (entry_q == 6'd63);
          if (entry_q == 6'd63) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            entry_d = entry_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_last_d  = emit_last;
    end else if (cfg_accept_i) begin
      out_valid_d = 1'b0;
    end

    // tq_q cannot advance while a last byte is still pending, so it names that byte's table.
    if (out_valid_q && out_last_q && cfg_accept_i) set_loaded[tq_q] = 1'b1;

    loaded_d = (img_start_i ? 4'b0 : loaded_q) | set_loaded;
    error_d  = (img_start_i ? 1'b0 : error_q) | set_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_hi_q    <= '0;
      rem_q       <= '0;
      entry_q     <= '0;
      tq_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      loaded_q    <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
`ifdef JPEG_DQT_16BIT_EN
      pq_q        <= 1'b0;
      msb_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      rem_q       <= rem_d;
      entry_q     <= entry_d;
      tq_q        <= tq_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      loaded_q    <= loaded_d;
      error_q     <= error_d;
      done_q      <= done_d;
`ifdef JPEG_DQT_16BIT_EN
      pq_q        <= pq_d;
      msb_q       <= msb_d;
`endif
    end
  end

  assign cfg_valid_o     = out_valid_q;
  assign cfg_data_o      = out_data_q;
  assign cfg_last_o      = out_last_q;
  assign tables_loaded_o = loaded_q;
  assign error_o         = error_q;
  assign done_o          = done_q;
  assign busy_o          = (state_q != S_IDLE) || out_valid_q;

endmodule
